// File: rtl/accel_pkg.sv
// Shared accelerator constants: partial-sum and lane widths and the simd_mode encoding of the PE array.
package accel_pkg;
  localparam int PSUM_W = 32;
  localparam int LANE_W = 16;

  localparam logic SIMD_MODE_16X2 = 1'b0;
  localparam logic SIMD_MODE_32   = 1'b1;

  typedef logic [PSUM_W-1:0] psum_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head: rd_data shows the head entry and keeps its last value when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en & ~full;
  assign do_pop  = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head register follows the entry behind the popped one, or bypasses a write into an emptying FIFO.
      if (do_pop) begin
        if (count > CW'(1))  rd_data <= mem[rd_ptr + 1'b1];
        else if (do_push)    rd_data <= wr_data;
      end else if (empty && do_push) begin
        rd_data <= wr_data;
      end
    end
  end
endmodule

// File: rtl/psum_accumulator.sv
// Per-row partial-sum accumulator below a PE column: lane-aware accumulation over K-passes, results queued for writeback.
module psum_accumulator
  import accel_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              simd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PSUM_W-1:0] sum_in,
  input  logic              first,
  input  logic              last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] out_data,
  output logic              busy,
  output logic              mode_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

  logic [PTR_W-1:0] ptr;
  psum_t            acc [DEPTH];
  logic             mode_lat;
  logic             accept;
  logic             push;
  psum_t            base;
  psum_t            sum_new;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_fifo_full;

  // Dual-lane mode keeps the two 16-bit halves independent: no carry crosses bit 15.
  function automatic psum_t lane_add(input psum_t a, input psum_t b, input logic mode);
    logic [LANE_W-1:0] lo;
    logic [LANE_W-1:0] hi;
    if (mode == SIMD_MODE_32) return a + b;
    lo = a[LANE_W-1:0] + b[LANE_W-1:0];
    hi = a[PSUM_W-1:LANE_W] + b[PSUM_W-1:LANE_W];
    return {hi, lo};
  endfunction

  assign in_ready         = (fifo_count < CNT_W'(OUT_DEPTH));
  assign out_valid        = ~fifo_empty;
  assign accept           = in_valid & in_ready;
  assign push             = accept & last;
  assign base             = first ? '0 : acc[ptr];
  assign sum_new          = lane_add(base, sum_in, simd_mode);
  assign unused_fifo_full = fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      busy     <= 1'b0;
      mode_lat <= SIMD_MODE_32;
      mode_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        acc[ptr] <= last ? '0 : sum_new;
        ptr      <= ptr + 1'b1;
        busy     <= (ptr != PTR_W'(DEPTH - 1));
        if (ptr == '0) mode_lat <= simd_mode;
      end
      if (busy && (simd_mode != mode_lat)) mode_err <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (PSUM_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (sum_new),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_psum_accumulator;
  localparam int DEPTH     = 4;
  localparam int OUT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        simd_mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum_in;
  logic        first;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        mode_err;

  int checks   = 0;
  int failures = 0;

  // Reference state: per-row sums, queued results, row index, latched mode.
  bit [31:0] m_acc [DEPTH];
  bit [31:0] m_q [$];
  bit [31:0] m_last;
  int        m_ptr;
  bit        m_busy;
  bit        m_lat;
  bit        m_err;

  psum_accumulator #(.DEPTH(DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .simd_mode (simd_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .first     (first),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .mode_err  (mode_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] ref_add(input bit [31:0] a, input bit [31:0] b, input bit mode);
    longint lo, hi;
    if (mode) return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
    lo = ((longint'(a) % 65536) + (longint'(b) % 65536)) % 65536;
    hi = ((longint'(a) / 65536) + (longint'(b) / 65536)) % 65536;
    return 32'(hi * 65536 + lo);
  endfunction

  task automatic model_edge();
    bit        take, pop;
    bit [31:0] base, nv;
    if (rst) begin
      foreach (m_acc[i]) m_acc[i] = 0;
      m_q.delete();
      m_last = 0; m_ptr = 0; m_busy = 0; m_lat = 1; m_err = 0;
      return;
    end
    take = in_valid && (m_q.size() < OUT_DEPTH);
    pop  = out_ready && (m_q.size() > 0);
    if (m_busy && (simd_mode != m_lat)) m_err = 1;
    if (pop) void'(m_q.pop_front());
    if (take) begin
      base = first ? 32'd0 : m_acc[m_ptr];
      nv   = ref_add(base, sum_in, simd_mode);
      if (last) begin
        m_q.push_back(nv);
        m_acc[m_ptr] = 0;
      end else begin
        m_acc[m_ptr] = nv;
      end
      if (m_ptr == 0) m_lat = simd_mode;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
    m_busy = (m_ptr != 0);
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic check_all();
    check("in_ready",  {31'd0, in_ready},  {31'd0, m_q.size() < OUT_DEPTH});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
    check("out_data",  out_data, m_last);
    check("busy",      {31'd0, busy},      {31'd0, m_busy});
    check("mode_err",  {31'd0, mode_err},  {31'd0, m_err});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic beat(input bit [31:0] v, input bit f, input bit l);
    in_valid = 1; sum_in = v; first = f; last = l;
    tick();
    in_valid = 0;
  endtask

  task automatic drain(input int n);
    out_ready = 1;
    repeat (n) tick();
    out_ready = 0;
  endtask

  initial begin
    rst = 1; simd_mode = 1; in_valid = 0; sum_in = 0; first = 0; last = 0; out_ready = 0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 0;

    // 32-bit two-pass accumulation
    simd_mode = 1;
    for (int i = 1; i <= 4; i++) beat(32'(i), 1, 0);
    for (int i = 1; i <= 4; i++) beat(32'(10 * i), 0, 1);
    check("pass_head0", out_data, 32'd11);
    check("pass_busy", {31'd0, busy}, 32'd0);
    out_ready = 1;
    tick(); check("pass_head1", out_data, 32'd22);
    tick(); check("pass_head2", out_data, 32'd33);
    tick(); check("pass_head3", out_data, 32'd44);
    tick(); check("pass_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 0;

    // Dual 16-bit lanes: low lane wraps without carrying into the high lane
    simd_mode = 0;
    beat(32'h0001_FFFF, 1, 0);
    for (int i = 1; i < DEPTH; i++) beat(32'd0, 1, 0);
    beat(32'h0002_0001, 0, 1);
    for (int i = 1; i < DEPTH; i++) beat(32'd0, 0, 1);
    check("simd_lanes", out_data, 32'h0003_0000);
    drain(4);

    // Backpressure with a full output queue
    for (int i = 0; i < 4; i++) beat(32'hA + 32'(i), 1, 1);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1; sum_in = 32'hE; first = 1; last = 1;
    tick(); tick();
    check("bp_hold_head", out_data, 32'hA);
    out_ready = 1;
    tick(); check("bp_pop_a", out_data, 32'hB);
    tick(); check("bp_pop_b", out_data, 32'hC);
    in_valid = 0;
    tick(); check("bp_pop_c", out_data, 32'hD);
    tick(); check("bp_pop_d", out_data, 32'hE);
    tick(); check("bp_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 0;

    // Simultaneous push and pop at two entries
    beat(32'd1, 1, 1);
    beat(32'd2, 1, 1);
    out_ready = 1;
    beat(32'd3, 1, 1);
    out_ready = 0;
    check("pp_head", out_data, 32'd2);
    out_ready = 1;
    tick(); check("pp_next", out_data, 32'd3);
    tick();
    out_ready = 0;

    // Reset in the middle of a tile
    rst = 1; tick(); rst = 0;
    beat(32'd7, 1, 1);
    beat(32'd8, 1, 0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1; tick(); rst = 0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    beat(32'h55, 1, 1);
    check("mid_after", out_data, 32'h55);
    drain(1);

    // Mode change while busy is sticky until reset
    simd_mode = 1;
    tick();
    check("mode_err_set", {31'd0, mode_err}, 32'd1);
    simd_mode = 0;
    tick(); tick();
    check("mode_err_sticky", {31'd0, mode_err}, 32'd1);
    rst = 1; tick(); rst = 0;
    check("mode_err_clr", {31'd0, mode_err}, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      sum_in    = $urandom();
      first     = ($urandom_range(0, 2) == 0);
      last      = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 63) == 0) simd_mode = ~simd_mode;
      tick();
    end
    rst = 0; in_valid = 0;
    drain(OUT_DEPTH + 1);
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
